// File: rtl/tpu_command_assembler_pkg.sv
// Shared TPU command definitions: opcode values, command width, FSM state
// types and the opcode-to-length table used by the assembler and host model.
package tpu_command_assembler_pkg;

    localparam int TPU_CMD_WIDTH = 48;

    localparam logic [7:0] OP_CLEARSCREEN = 8'h01;
    localparam logic [7:0] OP_PRINT       = 8'h02;
    localparam logic [7:0] OP_LOCATE      = 8'h03;
    localparam logic [7:0] OP_SETATTR     = 8'h04;
    localparam logic [7:0] OP_SETMASK     = 8'h05;

    typedef enum logic [1:0] {
        A_IDLE    = 2'd0,
        A_COLLECT = 2'd1,
        A_PUSH    = 2'd2
    } asm_state_t;

    typedef enum logic [1:0] {
        D_IDLE   = 2'd0,
        D_ISSUE  = 2'd1,
        D_SETTLE = 2'd2,
        D_WAIT   = 2'd3
    } disp_state_t;

    // Total command length in bytes, opcode included. Unknown opcodes are
    // forwarded as single-byte commands.
    function automatic logic [2:0] cmd_length(input logic [7:0] opcode);
        logic [2:0] len;
        case (opcode)
            OP_CLEARSCREEN: len = 3'd1;
            OP_PRINT:       len = 3'd2;
            OP_LOCATE:      len = 3'd3;
            OP_SETATTR:     len = 3'd3;
            OP_SETMASK:     len = 3'd4;
            default:        len = 3'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/tpu_cmd_fifo.sv
// Synchronous FIFO for packed TPU commands. DEPTH must be a power of two.
// A push into a full FIFO succeeds when a pop happens in the same cycle.
module tpu_cmd_fifo #(
    parameter int WIDTH = 48,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_pop_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full     = (r_count == FULL_CNT);
    assign o_empty    = (r_count == CNT_ZERO);
    assign w_pop_ok   = i_pop && !o_empty;
    assign w_push_ok  = i_push && (!o_full || w_pop_ok);
    assign o_pop_data = r_mem[r_rd_ptr];

    // Storage array write port; contents need no reset since the count gates reads.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= PTR_ZERO;
            r_rd_ptr <= PTR_ZERO;
            r_count  <= CNT_ZERO;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/tpu_command_assembler.sv
// Packs host bytes into 48-bit TPU commands and dispatches them to the TPU.
// Build option: define TPU_CMDQUEUE_EN to place a QUEUE_DEPTH-entry command
// FIFO between assembler and dispatcher; otherwise a single holding register.
module tpu_command_assembler
    import tpu_command_assembler_pkg::*;
#(
    parameter int BYTE_TIMEOUT = 1_000_000,
    parameter int QUEUE_DEPTH  = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     rx_valid,
    input  logic [7:0]               rx_byte,
    output logic                     rx_ready,
    input  logic                     tpu_busy,
    output logic                     tpu_execute,
    output logic [TPU_CMD_WIDTH-1:0] tpu_command,
    output logic                     timeout_error,
    output logic [7:0]               dropped_count
);

    localparam logic [31:0] TMO_LAST = 32'(BYTE_TIMEOUT - 1);
    localparam logic        TMO_EN   = (BYTE_TIMEOUT != 0);

    asm_state_t                r_asm_state;
    logic [TPU_CMD_WIDTH-1:0]  r_asm_cmd;
    logic [2:0]                r_len;
    logic [2:0]                r_idx;
    logic [31:0]               r_tmo_cnt;
    logic                      r_timeout_error;
    logic [7:0]                r_dropped_count;

    disp_state_t               r_disp_state;
    logic                      r_execute;
    logic [TPU_CMD_WIDTH-1:0]  r_command;

    logic                      w_accept;
    logic                      w_push;
    logic                      w_pop;
    logic                      w_store_full;
    logic                      w_store_empty;
    logic [TPU_CMD_WIDTH-1:0]  w_store_data;
    logic                      w_tmo_run;
    logic                      w_tmo_hit;

    assign rx_ready  = (r_asm_state != A_PUSH) && !w_store_full;
    assign w_accept  = rx_valid && rx_ready;
    assign w_pop     = (r_disp_state == D_ISSUE);
    assign w_push    = (r_asm_state == A_PUSH) && (!w_store_full || w_pop);
    // The timeout only counts idle collect cycles in which the host could
    // have delivered a byte; a full store pauses it.
    assign w_tmo_run = TMO_EN && (r_asm_state == A_COLLECT) && !w_store_full && !w_accept;
    assign w_tmo_hit = w_tmo_run && (r_tmo_cnt == TMO_LAST);

`ifdef TPU_CMDQUEUE_EN
    tpu_cmd_fifo #(
        .WIDTH (TPU_CMD_WIDTH),
        .DEPTH (QUEUE_DEPTH)
    ) u_cmd_fifo (
        .clk         (clk),
        .rst         (reset),
        .i_push      (w_push),
        .i_push_data (r_asm_cmd),
        .i_pop       (w_pop),
        .o_pop_data  (w_store_data),
        .o_full      (w_store_full),
        .o_empty     (w_store_empty)
    );
`else
    logic                     r_hold_valid;
    logic [TPU_CMD_WIDTH-1:0] r_hold_cmd;
    logic [4:0]               w_unused_depth;

    assign w_unused_depth = 5'(QUEUE_DEPTH);
    assign w_store_full   = r_hold_valid;
    assign w_store_empty  = !r_hold_valid;
    assign w_store_data   = r_hold_cmd;

    // Single-entry holding register; a push in the pop cycle keeps it valid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_cmd   <= {TPU_CMD_WIDTH{1'b0}};
        end else if (w_push) begin
            r_hold_valid <= 1'b1;
            r_hold_cmd   <= r_asm_cmd;
        end else if (w_pop) begin
            r_hold_valid <= 1'b0;
        end else begin
            r_hold_valid <= r_hold_valid;
        end
    end
`endif

    // Assembler FSM: opcode capture, parameter collection, timeout drop, push.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_asm_state     <= A_IDLE;
            r_asm_cmd       <= {TPU_CMD_WIDTH{1'b0}};
            r_len           <= 3'd1;
            r_idx           <= 3'd0;
            r_tmo_cnt       <= 32'd0;
            r_timeout_error <= 1'b0;
            r_dropped_count <= 8'd0;
        end else begin
            r_timeout_error <= 1'b0;
            case (r_asm_state)
                A_IDLE: begin
                    r_tmo_cnt <= 32'd0;
                    if (w_accept) begin
                        r_asm_cmd <= {40'd0, rx_byte};
                        r_len     <= cmd_length(rx_byte);
                        if (cmd_length(rx_byte) == 3'd1) begin
                            r_asm_state <= A_PUSH;
                        end else begin
                            r_idx       <= 3'd1;
                            r_asm_state <= A_COLLECT;
                        end
                    end
                end
                A_COLLECT: begin
                    if (w_accept) begin
                        r_asm_cmd[{r_idx, 3'b000} +: 8] <= rx_byte;
                        r_tmo_cnt <= 32'd0;
                        if (r_idx == r_len - 3'd1) begin
                            r_idx       <= 3'd0;
                            r_asm_state <= A_PUSH;
                        end else begin
                            r_idx <= r_idx + 3'd1;
                        end
                    end else if (w_tmo_hit) begin
                        r_asm_state     <= A_IDLE;
                        r_asm_cmd       <= {TPU_CMD_WIDTH{1'b0}};
                        r_idx           <= 3'd0;
                        r_tmo_cnt       <= 32'd0;
                        r_timeout_error <= 1'b1;
                        if (r_dropped_count != 8'hFF) begin
                            r_dropped_count <= r_dropped_count + 8'd1;
                        end
                    end else if (w_tmo_run) begin
                        r_tmo_cnt <= r_tmo_cnt + 32'd1;
                    end
                end
                A_PUSH: begin
                    if (w_push) begin
                        r_asm_state <= A_IDLE;
                    end
                end
                default: begin
                    r_asm_state <= A_IDLE;
                end
            endcase
        end
    end

    // Dispatcher FSM: issue one command per execute strobe and wait out busy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_disp_state <= D_IDLE;
            r_execute    <= 1'b0;
            r_command    <= {TPU_CMD_WIDTH{1'b0}};
        end else begin
            r_execute <= 1'b0;
            case (r_disp_state)
                D_IDLE: begin
                    if (!w_store_empty && !tpu_busy) begin
                        r_disp_state <= D_ISSUE;
                        r_execute    <= 1'b1;
                        r_command    <= w_store_data;
                    end
                end
                D_ISSUE:  r_disp_state <= D_SETTLE;
                // TPU raises busy one cycle after execute, so skip a cycle before looking.
                D_SETTLE: r_disp_state <= D_WAIT;
                D_WAIT: begin
                    if (!tpu_busy) begin
                        r_disp_state <= D_IDLE;
                    end
                end
                default: r_disp_state <= D_IDLE;
            endcase
        end
    end

    assign tpu_execute   = r_execute;
    assign tpu_command   = r_command;
    assign timeout_error = r_timeout_error;
    assign dropped_count = r_dropped_count;

endmodule
